bram_2p_arbiter: RTL and testbench
==================================

# bram_2p_arbiter

Two-client arbiter that shares one `bram_2p` instance between two requesters, for example two `sum_of_array`-style kernels or a kernel plus a host loader. The read port and write port are arbitrated independently with round-robin priority. A per-client lock lets one requester own the memory across a multi-cycle loop. It sits between the kernels and the `bram_2p` in the top level, replacing the direct kernel-to-BRAM wiring.

## Interface
Parameters:
- `ADDR_W`, default 10: BRAM address width.
- `DATA_W`, default 32: BRAM data width.

Ports (index k ∈ {0,1} selects client k; packed vectors are client-major, client 0 in the low slice):
- `clk`  in  1  sole clock. Reset is synchronous and active-low.
- `rst_n`  in  1  synchronous active-low reset.
- `rd_req`  in  2  read request per client; held until granted.
- `rd_addr`  in  2*ADDR_W  read address per client.
- `rd_gnt`  out  2  read grant, combinational, same cycle as the request.
- `rd_valid`  out  2  read data valid for client k, one cycle after `rd_gnt[k]`.
- `rd_data`  out  DATA_W  shared read data bus, equal to `mem_read_val`.
- `wr_req`  in  2  write request per client; held until granted.
- `wr_addr`  in  2*ADDR_W  write address per client.
- `wr_data`  in  2*DATA_W  write data per client.
- `wr_gnt`  out  2  write grant, combinational; the write commits at the clock edge ending the grant cycle.
- `lock`  in  2  client k requests exclusive ownership of both ports.
- `mem_clk`  out  1  equals `clk`.
- `mem_read_en`, `mem_read_addr`, `mem_read_val`: BRAM read port (`mem_read_val` is an input).
- `mem_write_en`, `mem_write_addr`, `mem_write_val`: BRAM write port.

## Operation
- Ownership FSM `state ∈ {IDLE, LOCK0, LOCK1}`, registered.
- **IDLE**
  - The read port grants at most one requester per cycle. The winner is `rr_rd` if it is requesting, otherwise the other client.
  - The write port is handled the same way, using `rr_wr`.
  - After a grant to client k, the corresponding pointer moves to 1-k. A port with no grant keeps its pointer.
- **Lock entry (from IDLE)**
  - If the read grant goes to k and `lock[k]`=1, next state is LOCKk.
  - Otherwise, if the write grant goes to k and `lock[k]`=1, next state is LOCKk.
  - The read-port check takes precedence.
- **LOCKk with `lock[k]`=1**
  - Only client k can be granted on either port. Requests from 1-k stall.
  - Round-robin pointers are frozen.
- **LOCKk with `lock[k]`=0**
  - The lock is treated as released in that same cycle: arbitration behaves exactly as in IDLE.
  - Next state is IDLE, or a new LOCK per the entry rule.
- **Memory side**
  - `mem_read_en` = |`rd_gnt`, with `mem_read_addr` taken from the granted client.
  - Write side uses the same scheme.
  - Ungranted address and data outputs are driven to 0.
- **Read return**
  - A 2-bit `rd_owner` register captures `rd_gnt`.
  - `rd_valid` = `rd_owner`, so the BRAM read latency is 1.
- **Same-address read and write in one cycle:** passed through unmodified; the result follows `bram_2p` behaviour. The arbiter does not detect or resolve this collision.

## Timing
- **Reset** (`rst_n`=0 at a clock edge)
  - `state`=IDLE, `rr_rd`=`rr_wr`=0, `rd_owner`=0.
  - All outputs are 0 during reset except `mem_clk` and `rd_data`.
  - Reset mid-read discards the pending `rd_valid`.
- **Grants:** combinational from `req`, `lock`, `state` and the pointers. No combinational path from `rd_gnt` back into `req` is permitted.
- **Throughput:** one read and one write per cycle total across both clients. A lone requester gets a grant every cycle.
- **Fairness:** in IDLE, under continuous contention, grants alternate 0,1,0,1. Worst-case wait is 1 cycle. Under a lock, the wait is unbounded.

## Structure
- Package `bram_arb_pkg`: `ADDR_W`/`DATA_W` defaults, the `arb_state_t` enum (IDLE, LOCK0, LOCK1), and client index constants.
- Sub-module `rr_arb2`: 2-way round-robin with a mask input, inputs `req[1:0]` and `mask[1:0]`, output `gnt[1:0]`, and an internal pointer with an advance-on-grant rule. It is instantiated once for reads and once for writes.
  - LOCKk is implemented as a mask, plus a hold that freezes the pointer.
- Top: FSM, address/data muxes, and the `rd_owner` register.

## Test plan
- **Single client:** `rd_req`=01, addr0=5 → `rd_gnt`=01, `mem_read_addr`=5; next cycle `rd_valid`=01 and `rd_data` = the BRAM word at 5.
- **Contention:** `rd_req`=11 held for 4 cycles after reset → `rd_gnt` sequence 01,10,01,10; `rd_valid` follows one cycle later.
- **Lock:**
  - Stimulus: client 1 asserts `lock`=10 with `wr_req`=10, then holds the lock for 5 cycles while client 0 continuously requests both ports.
  - Response: only client 1 is granted for those 5 cycles. In the cycle `lock` drops to 0, client 0 is granted on both ports.
- **Independent ports:** `rd_req`=01 and `wr_req`=10 in the same cycle → both granted, `mem_read_en`=`mem_write_en`=1. Write 0xDEADBEEF to address 7, then read address 7 → `rd_data`=0xDEADBEEF.
- **Reset mid-operation:** grant a read to client 0, assert `rst_n`=0 in the next cycle → `rd_valid`=00, `state`=IDLE, and the first post-reset contention grants client 0.
- **Lock precedence:** in IDLE, `lock`=11 with read granted to 0 and write granted to 1 → next state LOCK0; client 1's write still commits.

Source files
------------

// File: rtl/bram_2p_arbiter_pkg.sv
// Shared types and defaults for the two-client bram_2p arbiter.
package bram_arb_pkg;

    localparam int unsigned ADDR_W_DEF = 10;
    localparam int unsigned DATA_W_DEF = 32;

    localparam int unsigned CLIENT0 = 0;
    localparam int unsigned CLIENT1 = 1;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StLock0 = 2'd1,
        StLock1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/bram_2p_arbiter_if.sv
// Client-side bus of the arbiter: per-client read/write requests, grants and lock.
interface bram_2p_arbiter_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
);
    logic [1:0]          rd_req;
    logic [2*ADDR_W-1:0] rd_addr;
    logic [1:0]          rd_gnt;
    logic [1:0]          rd_valid;
    logic [DATA_W-1:0]   rd_data;
    logic [1:0]          wr_req;
    logic [2*ADDR_W-1:0] wr_addr;
    logic [2*DATA_W-1:0] wr_data;
    logic [1:0]          wr_gnt;
    logic [1:0]          lock;

    modport master (
        output rd_req, rd_addr, wr_req, wr_addr, wr_data, lock,
        input  rd_gnt, rd_valid, rd_data, wr_gnt
    );

    modport slave (
        input  rd_req, rd_addr, wr_req, wr_addr, wr_data, lock,
        output rd_gnt, rd_valid, rd_data, wr_gnt
    );
endinterface

// File: rtl/bram_2p_arbiter_rr_arb2.sv
// Two-way round-robin arbiter with request mask; pointer moves past the winner
// unless hold is asserted.
module rr_arb2 (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [1:0] req,
    input  logic [1:0] mask,
    input  logic       hold,
    output logic [1:0] gnt
);
    logic       ptr_q, ptr_d;
    logic [1:0] req_m;

    always_comb begin
        req_m = req & mask;
        gnt   = 2'b00;
        if (req_m[ptr_q]) begin
            gnt[ptr_q] = 1'b1;
        end else if (req_m[~ptr_q]) begin
            gnt[~ptr_q] = 1'b1;
        end
    end

    // After a grant to client k the pointer favours the other client.
    always_comb begin
        ptr_d = ptr_q;
        if ((gnt != 2'b00) && !hold) begin
            ptr_d = gnt[0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
endmodule

// File: rtl/bram_2p_arbiter.sv
// Shares one bram_2p between two clients: independent round-robin read and write
// ports, per-client lock for exclusive multi-cycle ownership.
module bram_2p_arbiter
    import bram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    bram_2p_arbiter_if.slave  bus,
    output logic              mem_clk,
    output logic              mem_read_en,
    output logic [ADDR_W-1:0] mem_read_addr,
    input  logic [DATA_W-1:0] mem_read_val,
    output logic              mem_write_en,
    output logic [ADDR_W-1:0] mem_write_addr,
    output logic [DATA_W-1:0] mem_write_val
);
    arb_state_t state_q, state_d;
    logic [1:0] mask;
    logic       hold;
    logic [1:0] rd_gnt, wr_gnt;
    logic [1:0] rd_owner_q;

    rr_arb2 u_rd_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (bus.rd_req),
        .mask (mask),
        .hold (hold),
        .gnt  (rd_gnt)
    );

    rr_arb2 u_wr_arb (
        .clk  (clk),
        .rst_n(rst_n),
        .req  (bus.wr_req),
        .mask (mask),
        .hold (hold),
        .gnt  (wr_gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // A held lock keeps ownership; otherwise the read grant is checked before the write.
    always_comb begin
        state_d = StIdle;
        if ((state_q == StLock0) && bus.lock[CLIENT0]) begin
            state_d = StLock0;
        end else if ((state_q == StLock1) && bus.lock[CLIENT1]) begin
            state_d = StLock1;
        end else if (rd_gnt[CLIENT0] && bus.lock[CLIENT0]) begin
            state_d = StLock0;
        end else if (rd_gnt[CLIENT1] && bus.lock[CLIENT1]) begin
            state_d = StLock1;
        end else if (wr_gnt[CLIENT0] && bus.lock[CLIENT0]) begin
            state_d = StLock0;
        end else if (wr_gnt[CLIENT1] && bus.lock[CLIENT1]) begin
            state_d = StLock1;
        end
    end

    // A dropped lock releases in the same cycle, so masking only applies while held.
    always_comb begin
        mask = 2'b11;
        hold = 1'b0;
        if (!rst_n) begin
            mask = 2'b00;
        end else begin
            unique case (state_q)
                StLock0: begin
                    if (bus.lock[CLIENT0]) begin
                        mask = 2'b01;
                        hold = 1'b1;
                    end
                end
                StLock1: begin
                    if (bus.lock[CLIENT1]) begin
                        mask = 2'b10;
                        hold = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_owner_q <= 2'b00;
        end else begin
            rd_owner_q <= rd_gnt;
        end
    end

    always_comb begin
        mem_read_addr  = '0;
        mem_write_addr = '0;
        mem_write_val  = '0;
        unique case (rd_gnt)
            2'b01:   mem_read_addr = bus.rd_addr[ADDR_W-1:0];
            2'b10:   mem_read_addr = bus.rd_addr[2*ADDR_W-1:ADDR_W];
            default: ;
        endcase
        unique case (wr_gnt)
            2'b01: begin
                mem_write_addr = bus.wr_addr[ADDR_W-1:0];
                mem_write_val  = bus.wr_data[DATA_W-1:0];
            end
            2'b10: begin
                mem_write_addr = bus.wr_addr[2*ADDR_W-1:ADDR_W];
                mem_write_val  = bus.wr_data[2*DATA_W-1:DATA_W];
            end
            default: ;
        endcase
    end

    assign mem_clk      = clk;
    assign mem_read_en  = |rd_gnt;
    assign mem_write_en = |wr_gnt;
    assign bus.rd_gnt   = rd_gnt;
    assign bus.wr_gnt   = wr_gnt;
    // Gated so a read pending when reset asserts never shows as valid.
    assign bus.rd_valid = rd_owner_q & {2{rst_n}};
    assign bus.rd_data  = mem_read_val;
endmodule

// File: tb/tb_bram_2p_arbiter.sv
// Self-checking bench for bram_2p_arbiter with a behavioural BRAM and reference model.
module tb_bram_2p_arbiter;
    localparam int unsigned AW = 10;
    localparam int unsigned DW = 32;
    localparam int unsigned NWORDS = 1 << AW;

    logic clk;
    logic rst_n;
    logic          mem_clk, mem_read_en, mem_write_en;
    logic [AW-1:0] mem_read_addr, mem_write_addr;
    logic [DW-1:0] mem_read_val, mem_write_val;

    bram_2p_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    bram_2p_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .mem_clk       (mem_clk),
        .mem_read_en   (mem_read_en),
        .mem_read_addr (mem_read_addr),
        .mem_read_val  (mem_read_val),
        .mem_write_en  (mem_write_en),
        .mem_write_addr(mem_write_addr),
        .mem_write_val (mem_write_val)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural bram_2p: one-cycle read latency, read returns the old word on collision.
    logic [DW-1:0] tb_mem [NWORDS];
    always @(posedge mem_clk) begin
        if (mem_read_en) mem_read_val <= tb_mem[mem_read_addr];
        if (mem_write_en) tb_mem[mem_write_addr] <= mem_write_val;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Reference model: owner is -1 when nobody holds the memory.
    int            m_owner;
    bit            m_ptr_rd, m_ptr_wr;
    logic [1:0]    m_pend;
    logic [DW-1:0] m_pend_data;
    logic [DW-1:0] ref_mem [NWORDS];

    function automatic int pick(input logic [1:0] req, input bit ptr);
        if (req[ptr]) return int'(ptr);
        if (req[!ptr]) return int'(!ptr);
        return -1;
    endfunction

    function automatic logic [1:0] onehot(input int k);
        if (k == 0) return 2'b01;
        if (k == 1) return 2'b10;
        return 2'b00;
    endfunction

    task automatic step(input logic rst, input logic [1:0] rq, input logic [1:0] wq,
                        input logic [1:0] lk, input logic [AW-1:0] ra0, input logic [AW-1:0] ra1,
                        input logic [AW-1:0] wa0, input logic [AW-1:0] wa1,
                        input logic [DW-1:0] wd0, input logic [DW-1:0] wd1);
        bit            locked;
        logic [1:0]    allow;
        int            rw, ww;
        logic [AW-1:0] ea_r, ea_w;
        logic [DW-1:0] ed_w;
        @(negedge clk);
        rst_n       = rst;
        bus.rd_req  = rq;
        bus.wr_req  = wq;
        bus.lock    = lk;
        bus.rd_addr = {ra1, ra0};
        bus.wr_addr = {wa1, wa0};
        bus.wr_data = {wd1, wd0};
        #1;
        locked = 1'b0;
        rw = -1;
        ww = -1;
        if (rst) begin
            locked = (m_owner >= 0) && lk[m_owner];
            allow  = locked ? onehot(m_owner) : 2'b11;
            rw = pick(rq & allow, m_ptr_rd);
            ww = pick(wq & allow, m_ptr_wr);
        end
        ea_r = (rw == 0) ? ra0 : (rw == 1) ? ra1 : '0;
        ea_w = (ww == 0) ? wa0 : (ww == 1) ? wa1 : '0;
        ed_w = (ww == 0) ? wd0 : (ww == 1) ? wd1 : '0;
        chk("rd_gnt", 64'(bus.rd_gnt), 64'(onehot(rw)));
        chk("wr_gnt", 64'(bus.wr_gnt), 64'(onehot(ww)));
        chk("mem_read_en", 64'(mem_read_en), 64'(rw >= 0));
        chk("mem_read_addr", 64'(mem_read_addr), 64'(ea_r));
        chk("mem_write_en", 64'(mem_write_en), 64'(ww >= 0));
        chk("mem_write_addr", 64'(mem_write_addr), 64'(ea_w));
        chk("mem_write_val", 64'(mem_write_val), 64'(ed_w));
        chk("rd_valid", 64'(bus.rd_valid), 64'(rst ? m_pend : 2'b00));
        if (rst && (m_pend != 2'b00)) chk("rd_data", 64'(bus.rd_data), 64'(m_pend_data));
        // State after the coming clock edge.
        if (!rst) begin
            m_owner  = -1;
            m_ptr_rd = 1'b0;
            m_ptr_wr = 1'b0;
            m_pend   = 2'b00;
        end else begin
            m_pend = onehot(rw);
            if (rw >= 0) m_pend_data = ref_mem[ea_r];
            if (ww >= 0) ref_mem[ea_w] = ed_w;
            if (!locked) begin
                if (rw >= 0) m_ptr_rd = (rw == 0);
                if (ww >= 0) m_ptr_wr = (ww == 0);
                if (rw >= 0 && lk[rw]) m_owner = rw;
                else if (ww >= 0 && lk[ww]) m_owner = ww;
                else m_owner = -1;
            end
        end
    endtask

    task automatic idle_step();
        step(1'b1, 2'b00, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
    endtask

    typedef struct {
        logic       rst;
        logic [1:0] rq, wq, lk;
        logic [1:0] e_rg, e_wg, e_rv;
    } vec_t;

    vec_t tbl [19];

    initial begin
        for (int i = 0; i < int'(NWORDS); i++) begin
            tb_mem[i]  <= 32'hA500_0000 + DW'(i);
            ref_mem[i] = 32'hA500_0000 + DW'(i);
        end
        m_owner = -1;
        m_ptr_rd = 1'b0;
        m_ptr_wr = 1'b0;
        m_pend = 2'b00;
        m_pend_data = '0;
        rst_n = 1'b0;
        bus.rd_req = '0;
        bus.wr_req = '0;
        bus.lock = '0;
        bus.rd_addr = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        // Reset, contention, lock by client 1, release, lock precedence, reset mid-read.
        tbl[0]  = '{1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[1]  = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
        tbl[2]  = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01};
        tbl[3]  = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b01, 2'b00, 2'b10};
        tbl[4]  = '{1'b1, 2'b11, 2'b00, 2'b00, 2'b10, 2'b00, 2'b01};
        tbl[5]  = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b10};
        tbl[6]  = '{1'b1, 2'b00, 2'b10, 2'b10, 2'b00, 2'b10, 2'b00};
        tbl[7]  = '{1'b1, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b00};
        for (int i = 8; i < 12; i++) tbl[i] = '{1'b1, 2'b11, 2'b11, 2'b10, 2'b10, 2'b10, 2'b10};
        tbl[12] = '{1'b1, 2'b11, 2'b11, 2'b00, 2'b01, 2'b01, 2'b10};
        tbl[13] = '{1'b1, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01};
        tbl[14] = '{1'b1, 2'b01, 2'b10, 2'b11, 2'b01, 2'b10, 2'b00};
        tbl[15] = '{1'b1, 2'b11, 2'b11, 2'b01, 2'b01, 2'b01, 2'b01};
        tbl[16] = '{1'b1, 2'b11, 2'b11, 2'b00, 2'b10, 2'b01, 2'b01};
        tbl[17] = '{1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00};
        tbl[18] = '{1'b1, 2'b11, 2'b11, 2'b00, 2'b01, 2'b01, 2'b00};

        for (int i = 0; i < 19; i++) begin
            step(tbl[i].rst, tbl[i].rq, tbl[i].wq, tbl[i].lk, '0, '0, '0, '0, '0, '0);
            chk($sformatf("tbl%0d_rd_gnt", i), 64'(bus.rd_gnt), 64'(tbl[i].e_rg));
            chk($sformatf("tbl%0d_wr_gnt", i), 64'(bus.wr_gnt), 64'(tbl[i].e_wg));
            chk($sformatf("tbl%0d_rd_valid", i), 64'(bus.rd_valid), 64'(tbl[i].e_rv));
        end

        // Single client read of address 5.
        step(1'b1, 2'b01, 2'b00, 2'b00, 10'd5, '0, '0, '0, '0, '0);
        chk("single_gnt", 64'(bus.rd_gnt), 64'(2'b01));
        chk("single_addr", 64'(mem_read_addr), 64'(5));
        idle_step();
        chk("single_valid", 64'(bus.rd_valid), 64'(2'b01));
        chk("single_data", 64'(bus.rd_data), 64'(32'hA500_0005));

        // Independent ports, then read back the written word.
        step(1'b1, 2'b01, 2'b10, 2'b00, 10'd3, '0, '0, 10'd7, '0, 32'hDEAD_BEEF);
        chk("indep_rd_gnt", 64'(bus.rd_gnt), 64'(2'b01));
        chk("indep_wr_gnt", 64'(bus.wr_gnt), 64'(2'b10));
        chk("indep_rd_en", 64'(mem_read_en), 64'(1));
        chk("indep_wr_en", 64'(mem_write_en), 64'(1));
        step(1'b1, 2'b01, 2'b00, 2'b00, 10'd7, '0, '0, '0, '0, '0);
        idle_step();
        chk("indep_readback", 64'(bus.rd_data), 64'(32'hDEAD_BEEF));

        // Lock precedence: read winner 0 takes the lock, client 1's write still lands.
        step(1'b1, 2'b01, 2'b10, 2'b11, 10'd1, '0, '0, 10'd20, '0, 32'h1234_5678);
        chk("prec_wr_gnt", 64'(bus.wr_gnt), 64'(2'b10));
        step(1'b1, 2'b11, 2'b11, 2'b01, 10'd2, 10'd3, 10'd21, 10'd22, '0, '0);
        chk("prec_lock0_rd", 64'(bus.rd_gnt), 64'(2'b01));
        chk("prec_lock0_wr", 64'(bus.wr_gnt), 64'(2'b01));
        step(1'b1, 2'b01, 2'b00, 2'b00, 10'd20, '0, '0, '0, '0, '0);
        idle_step();
        chk("prec_wr_commit", 64'(bus.rd_data), 64'(32'h1234_5678));

        // Reset while a read is in flight.
        step(1'b1, 2'b01, 2'b00, 2'b00, 10'd4, '0, '0, '0, '0, '0);
        step(1'b0, 2'b00, 2'b00, 2'b00, '0, '0, '0, '0, '0, '0);
        chk("rst_mid_valid", 64'(bus.rd_valid), 64'(2'b00));
        step(1'b1, 2'b11, 2'b11, 2'b00, '0, '0, '0, '0, '0, '0);
        chk("rst_post_rd", 64'(bus.rd_gnt), 64'(2'b01));
        chk("rst_post_wr", 64'(bus.wr_gnt), 64'(2'b01));

        // Random traffic against the model; locks persist for several cycles.
        begin
            logic [1:0] lk_r = 2'b00;
            for (int n = 0; n < 3000; n++) begin
                if ($urandom_range(0, 7) == 0) lk_r = 2'($urandom);
                step(($urandom_range(0, 49) != 0), 2'($urandom), 2'($urandom), lk_r,
                     AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                     AW'($urandom_range(0, 15)), AW'($urandom_range(0, 15)),
                     DW'($urandom), DW'($urandom));
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
